nrzi_stuff_serializer: RTL and testbench
========================================

# nrzi_stuff_serializer

Streaming transmit-side line encoder for the USB transceiver. It accepts parallel words over a valid/ready handshake and serialises them one bit per bit-time strobe. Each bit is NRZI encoded, with the line level carried across word boundaries, and a zero is bit-stuffed after every run of `STUFF_LIMIT` consecutive ones. It sits between the TX packet framer and the differential line driver. The line returns to the idle level (1, J) at every packet boundary.

## Interface
- `DATA_WIDTH`, 8: word width in bits, ≥2.
- `STUFF_LIMIT`, 6: number of consecutive data ones that forces a stuffed zero, ≥1.
- `LSB_FIRST`, 0: bit order. 0 sends `in_data[DATA_WIDTH-1]` first; 1 sends `in_data[0]` first.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `n_rst` input 1: asynchronous reset, active-low.
- `shift_en` input 1: bit-time strobe. One output bit per cycle in which it is high.
- `in_valid` input 1: `in_data` and `in_last` are valid.
- `in_data` input `DATA_WIDTH`: word to transmit.
- `in_last` input 1: this word ends the packet.
- `in_ready` output 1: a word is accepted on an edge where `in_valid && in_ready`. Combinational.
- `bit_out` output 1: current NRZI line level. Registered.
- `bit_strobe` output 1: one-cycle pulse; `bit_out` was updated at this edge. Registered.
- `stuff_bit` output 1: qualifies `bit_strobe`; the bit just emitted is a stuffed zero.
- `busy` output 1: high while the state is not IDLE.
- `pkt_done` output 1: one-cycle pulse when the packet completes normally.
- `underrun` output 1: one-cycle pulse when a packet aborts because data was missing.

## Operation
- **Internal state:** shift register (`DATA_WIDTH` bits), bit index, ones counter (width `$clog2(STUFF_LIMIT+1)`), `last_flag`, line level `lvl`.
- **FSM states:** IDLE, ACTIVE, TAIL_STUFF, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On accept: load the shift register, set `last_flag` = `in_last`, set bit index to 0, go to ACTIVE.
  - `lvl` = 1, ones counter = 0.
- **ACTIVE, each cycle with `shift_en` = 1:**
  - If ones counter == `STUFF_LIMIT`: emit a stuffed zero. `lvl` toggles, ones counter clears, `stuff_bit` = 1. No data bit is consumed.
  - Otherwise take the next data bit b in the order set by `LSB_FIRST`:
    - b = 1: `lvl` holds, ones counter increments.
    - b = 0: `lvl` toggles, ones counter clears.
  - Either way, `bit_out` takes the new `lvl` and `bit_strobe` pulses.
- **Consuming the final bit of a word:**
  - `last_flag` = 0 and `in_valid` = 1: `in_ready` is high this cycle. The next word loads at the same edge, so there is no gap bit. `lvl` and the ones counter carry over.
  - `last_flag` = 0 and `in_valid` = 0: pulse `underrun` and go to IDLE. `lvl` resets to 1; `bit_out` returns to 1 at that edge.
  - `last_flag` = 1: if the ones counter after this bit == `STUFF_LIMIT`, go to TAIL_STUFF; otherwise go to DONE.
- **TAIL_STUFF:** on the next `shift_en`, emit a stuffed zero as above, then go to DONE.
- **DONE:** lasts one cycle, independent of `shift_en`. Pulse `pkt_done`, set `lvl` = 1 and `bit_out` = 1, clear the ones counter, go to IDLE.
- **`in_ready` rule:** high only in IDLE, or in ACTIVE on a `shift_en` cycle that consumes the final data bit of a non-last word (never on a stuff cycle). Low everywhere else.
- **`shift_en` low:** freezes all bit state. No strobe is produced.

## Timing
- **Reset values:** `bit_out` = 1, `bit_strobe` = 0, `stuff_bit` = 0, `busy` = 0, `pkt_done` = 0, `underrun` = 0. State = IDLE, counters = 0, `lvl` = 1.
- **Reset mid-packet:** behaves as above. The partial packet is dropped and nothing is emitted.
- **Latency:** a word accepted at edge k has its first bit strobed at the first edge after k with `shift_en` = 1.
- **Output bit count per packet:** N·`DATA_WIDTH` + number of stuffed bits. `pkt_done` asserts on the edge after the final strobe.
- **Back-to-back packets:** a new packet can be accepted in the cycle immediately after DONE, since IDLE has `in_ready` = 1.
- **Stuff decision on a word boundary:** a stuff pending at the last bit of word n is emitted before the first bit of word n+1. That word n+1 was already accepted, and its bits are delayed by one strobe.
- **Simultaneous events:** `in_valid` is ignored whenever `in_ready` = 0. `shift_en` has no effect in IDLE or DONE.

## Test plan
- **Single word, MSB first:** word 0x80 with `in_last`, `shift_en` tied high. `bit_out` strobes 1,0,1,0,1,0,1,0, `stuff_bit` never asserts, `pkt_done` pulses one cycle after the 8th strobe, and `bit_out` is 1 afterward.
- **Mid-word stuffing:** word 0xFF with `in_last`. Nine strobes: 1,1,1,1,1,1,0(stuff),0,0. `stuff_bit` is high only on strobe 7.
- **Tail stuffing:** word 0x3F with `in_last`. Strobes 0,1,1,1,1,1,1,1,0. The 9th strobe is a stuffed zero issued from TAIL_STUFF, then `pkt_done` pulses.
- **Level continuity:** words 0x00 then 0x00 (last), with the second word presented before the first word ends. 16 alternating strobes 0,1,0,1,…; `in_ready` pulses once on the 8th strobe cycle, with no gap between words.
- **Underrun, then reset:**
  - Word 0xA5 without `in_last`, `in_valid` low afterward: `underrun` pulses after 8 strobes, `busy` drops, `bit_out` = 1.
  - Then start word 0xF0 and assert `n_rst` low after 3 strobes: all outputs go to reset values immediately, and no `pkt_done` pulse occurs.
- **Stall and LSB_FIRST = 1:** word 0x01 with `shift_en` high every third cycle. Strobes 1,0,1,0,1,0,1,0 appear exactly 3 cycles apart, and no state changes between strobes.

Source files
------------

// File: rtl/nrzi_stuff_serializer.sv
// nrzi_stuff_serializer
// Transmit-side USB line encoder. It accepts parallel words over a valid/ready
// handshake and serialises them one bit per bit-time strobe. Each bit is NRZI
// encoded, and the line level carries across word boundaries. A zero is stuffed
// after every run of STUFF_LIMIT data ones. The line returns to idle (1, J) at
// every packet boundary.
//
// Ports:
//   clk        - single clock, rising edge
//   n_rst      - asynchronous reset, active low
//   shift_en   - bit-time strobe; one output bit per cycle it is high
//   in_valid   - in_data / in_last are valid
//   in_data    - word to transmit
//   in_last    - word ends the packet
//   in_ready   - word accepted when in_valid && in_ready (combinational)
//   bit_out    - NRZI line level (registered)
//   bit_strobe - one-cycle pulse: bit_out was updated at this edge
//   stuff_bit  - qualifies bit_strobe: the emitted bit is a stuffed zero
//   busy       - FSM is not idle
//   pkt_done   - one-cycle pulse on normal packet completion
//   underrun   - one-cycle pulse when a packet aborts for lack of data
module nrzi_stuff_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int STUFF_LIMIT = 6,
    parameter int LSB_FIRST   = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  shift_en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  bit_out,
    output logic                  bit_strobe,
    output logic                  stuff_bit,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  underrun
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_WIDTH - 1);
    localparam logic [OW-1:0] ONES_STUF = OW'(STUFF_LIMIT);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACTIVE     = 2'd1,
        TAIL_STUFF = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Next data bit to transmit in the configured bit order.
    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] sr);
        if (LSB_FIRST != 0) begin
            return sr[0];
        end else begin
            return sr[DATA_WIDTH-1];
        end
    endfunction

    // Shift register after the head bit has been consumed.
    function automatic logic [DATA_WIDTH-1:0] drop_head(input logic [DATA_WIDTH-1:0] sr);
        if (LSB_FIRST != 0) begin
            return {1'b0, sr[DATA_WIDTH-1:1]};
        end else begin
            return {sr[DATA_WIDTH-2:0], 1'b0};
        end
    endfunction

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] shreg_r, shreg_s;
    logic [IW-1:0]         idx_r, idx_s;
    logic [OW-1:0]         ones_r, ones_s;
    logic                  last_r, last_s;
    logic                  lvl_r, lvl_s;
    logic                  bit_out_r, bit_out_s;
    logic                  strobe_r, strobe_s;
    logic                  stuff_r, stuff_s;
    logic                  busy_r;
    logic                  done_r, done_s;
    logic                  under_r, under_s;
    logic                  ready_s;
    logic                  data_bit_s;

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        idx_s      = idx_r;
        ones_s     = ones_r;
        last_s     = last_r;
        lvl_s      = lvl_r;
        bit_out_s  = bit_out_r;
        strobe_s   = 1'b0;
        stuff_s    = 1'b0;
        done_s     = 1'b0;
        under_s    = 1'b0;
        ready_s    = 1'b0;
        data_bit_s = head_bit(shreg_r);

        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                lvl_s   = 1'b1;
                ones_s  = {OW{1'b0}};
                if (in_valid) begin
                    shreg_s = in_data;
                    last_s  = in_last;
                    idx_s   = {IW{1'b0}};
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end

            ACTIVE: begin
                if (shift_en) begin
                    strobe_s = 1'b1;
                    if (ones_r == ONES_STUF) begin
                        // Stuffed zero: no data bit consumed, index holds.
                        lvl_s     = ~lvl_r;
                        ones_s    = {OW{1'b0}};
                        stuff_s   = 1'b1;
                        bit_out_s = ~lvl_r;
                    end else begin
                        if (data_bit_s) begin
                            lvl_s  = lvl_r;
                            ones_s = ones_r + OW'(1);
                        end else begin
                            lvl_s  = ~lvl_r;
                            ones_s = {OW{1'b0}};
                        end
                        bit_out_s = lvl_s;
                        shreg_s   = drop_head(shreg_r);
                        idx_s     = idx_r + IW'(1);
                        if (idx_r == LAST_IDX) begin
                            if (!last_r) begin
                                // Gapless hand-over: the next word loads on this edge.
                                ready_s = 1'b1;
                                if (in_valid) begin
                                    shreg_s = in_data;
                                    last_s  = in_last;
                                    idx_s   = {IW{1'b0}};
                                end else begin
                                    under_s   = 1'b1;
                                    state_s   = IDLE;
                                    lvl_s     = 1'b1;
                                    bit_out_s = 1'b1;
                                    ones_s    = {OW{1'b0}};
                                end
                            end else if (ones_s == ONES_STUF) begin
                                state_s = TAIL_STUFF;
                            end else begin
                                state_s = DONE;
                            end
                        end else begin
                            state_s = ACTIVE;
                        end
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end

            TAIL_STUFF: begin
                if (shift_en) begin
                    strobe_s  = 1'b1;
                    stuff_s   = 1'b1;
                    lvl_s     = ~lvl_r;
                    bit_out_s = ~lvl_r;
                    ones_s    = {OW{1'b0}};
                    state_s   = DONE;
                end else begin
                    state_s = TAIL_STUFF;
                end
            end

            DONE: begin
                done_s    = 1'b1;
                lvl_s     = 1'b1;
                bit_out_s = 1'b1;
                ones_s    = {OW{1'b0}};
                state_s   = IDLE;
            end

            default: begin
                state_s   = IDLE;
                lvl_s     = 1'b1;
                bit_out_s = 1'b1;
                ones_s    = {OW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= IDLE;
            shreg_r   <= {DATA_WIDTH{1'b0}};
            idx_r     <= {IW{1'b0}};
            ones_r    <= {OW{1'b0}};
            last_r    <= 1'b0;
            lvl_r     <= 1'b1;
            bit_out_r <= 1'b1;
            strobe_r  <= 1'b0;
            stuff_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            under_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            shreg_r   <= shreg_s;
            idx_r     <= idx_s;
            ones_r    <= ones_s;
            last_r    <= last_s;
            lvl_r     <= lvl_s;
            bit_out_r <= bit_out_s;
            strobe_r  <= strobe_s;
            stuff_r   <= stuff_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= done_s;
            under_r   <= under_s;
        end
    end

    assign in_ready   = ready_s;
    assign bit_out    = bit_out_r;
    assign bit_strobe = strobe_r;
    assign stuff_bit  = stuff_r;
    assign busy       = busy_r;
    assign pkt_done   = done_r;
    assign underrun   = under_r;

endmodule

// File: tb/tb_nrzi_stuff_serializer.sv
// Self-checking bench for nrzi_stuff_serializer: an MSB-first instance driven by
// a table of single-word packets plus hand-written multi-cycle sequences, and an
// LSB-first instance exercised with a sparse bit-time strobe.
module tb_nrzi_stuff_serializer;

    logic       clk;
    logic       n_rst;

    logic       a_shift, a_valid, a_last;
    logic [7:0] a_data;
    logic       a_ready, a_bit, a_strobe, a_stuff, a_busy, a_done, a_under;

    logic       b_shift, b_valid, b_last;
    logic [7:0] b_data;
    logic       b_ready, b_bit, b_strobe, b_stuff, b_busy, b_done, b_under;

    int pass_cnt;
    int total_cnt;

    nrzi_stuff_serializer #(.DATA_WIDTH(8), .STUFF_LIMIT(6), .LSB_FIRST(0)) u_msb (
        .clk(clk), .n_rst(n_rst), .shift_en(a_shift), .in_valid(a_valid),
        .in_data(a_data), .in_last(a_last), .in_ready(a_ready), .bit_out(a_bit),
        .bit_strobe(a_strobe), .stuff_bit(a_stuff), .busy(a_busy),
        .pkt_done(a_done), .underrun(a_under)
    );

    nrzi_stuff_serializer #(.DATA_WIDTH(8), .STUFF_LIMIT(6), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .n_rst(n_rst), .shift_en(b_shift), .in_valid(b_valid),
        .in_data(b_data), .in_last(b_last), .in_ready(b_ready), .bit_out(b_bit),
        .bit_strobe(b_strobe), .stuff_bit(b_stuff), .busy(b_busy),
        .pkt_done(b_done), .underrun(b_under)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        int         nbits;
        logic [15:0] bits;
        logic [15:0] stuff;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Collect strobes from the MSB instance until pkt_done/underrun or the budget expires.
    task automatic collect(input int limit, output logic [15:0] bits, output logic [15:0] stuff,
                           output int n, output int done_at, output int under_at,
                           output int last_at);
        bits = 16'h0000; stuff = 16'h0000; n = 0;
        done_at = -1; under_at = -1; last_at = -1;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            if (a_strobe) begin
                bits  = {bits[14:0], a_bit};
                stuff = {stuff[14:0], a_stuff};
                n++;
                last_at = c;
            end
            if (a_done && done_at < 0) done_at = c;
            if (a_under && under_at < 0) under_at = c;
            if (done_at >= 0 || under_at >= 0) break;
        end
    endtask

    initial begin
        logic [15:0] bits, stuff;
        int n, done_at, under_at, last_at;
        int rdy_cnt, rdy_at, seen;
        bit pend;
        int prev_at, first_at, gap_err, hold_err;
        logic held;

        pass_cnt = 0; total_cnt = 0;
        vecs[0] = '{"msb_0x80",  8'h80, 8, 16'h00AA, 16'h0000};
        vecs[1] = '{"mid_stuff", 8'hFF, 9, 16'h01F8, 16'h0004};
        vecs[2] = '{"tail_stuff",8'h3F, 9, 16'h00FE, 16'h0001};

        n_rst = 1'b0;
        a_shift = 1'b1; a_valid = 1'b0; a_last = 1'b0; a_data = 8'h00;
        b_shift = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00;
        #12;
        check("rst_bit_out",  {31'd0, a_bit},    32'd1);
        check("rst_strobe",   {31'd0, a_strobe}, 32'd0);
        check("rst_stuff",    {31'd0, a_stuff},  32'd0);
        check("rst_busy",     {31'd0, a_busy},   32'd0);
        check("rst_pkt_done", {31'd0, a_done},   32'd0);
        check("rst_underrun", {31'd0, a_under},  32'd0);
        check("rst_ready",    {31'd0, a_ready},  32'd1);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Single-word packets, shift_en tied high.
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_data = vecs[i].data; a_last = 1'b1;
            @(posedge clk); #1;
            a_valid = 1'b0;
            collect(30, bits, stuff, n, done_at, under_at, last_at);
            check({vecs[i].name, "_count"}, n, vecs[i].nbits);
            check({vecs[i].name, "_bits"},  {16'h0000, bits},  {16'h0000, vecs[i].bits});
            check({vecs[i].name, "_stuff"}, {16'h0000, stuff}, {16'h0000, vecs[i].stuff});
            check({vecs[i].name, "_done_timing"}, done_at, last_at + 1);
            check({vecs[i].name, "_idle_level"}, {31'd0, a_bit}, 32'd1);
            @(posedge clk); #1;
            check({vecs[i].name, "_busy_after"}, {31'd0, a_busy}, 32'd0);
        end

        // Level continuity across two words with the second presented early.
        a_valid = 1'b1; a_data = 8'h00; a_last = 1'b0;
        @(posedge clk); #1;
        a_last = 1'b1;
        bits = 16'h0000; n = 0; rdy_cnt = 0; rdy_at = -1; done_at = -1; pend = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (pend) begin a_valid = 1'b0; pend = 1'b0; end
            #1;
            if (a_strobe) begin bits = {bits[14:0], a_bit}; n++; last_at = c; end
            if (a_done) begin done_at = c; break; end
            if (a_ready && a_busy) begin
                rdy_cnt++; rdy_at = n;
                if (a_valid) pend = 1'b1;
            end
        end
        check("cont_count",      n, 16);
        check("cont_bits",       {16'h0000, bits}, 32'h0000_5555);
        check("cont_ready_cnt",  rdy_cnt, 1);
        check("cont_ready_slot", rdy_at, 7);
        check("cont_done",       done_at, last_at + 1);
        @(posedge clk); #1;

        // Underrun: non-last word with no follow-up.
        a_valid = 1'b1; a_data = 8'hA5; a_last = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        collect(30, bits, stuff, n, done_at, under_at, last_at);
        check("under_count",   n, 8);
        check("under_bits",    {16'h0000, bits}, 32'h0000_0093);
        check("under_timing",  under_at, last_at);
        check("under_no_done", done_at, -1);
        check("under_busy",    {31'd0, a_busy}, 32'd0);
        check("under_level",   {31'd0, a_bit},  32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a packet.
        a_valid = 1'b1; a_data = 8'hF0; a_last = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            @(posedge clk); #1;
            if (a_strobe) n++;
        end
        check("mid_rst_strobes", n, 3);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_bit_out", {31'd0, a_bit},    32'd1);
        check("mid_rst_strobe",  {31'd0, a_strobe}, 32'd0);
        check("mid_rst_busy",    {31'd0, a_busy},   32'd0);
        check("mid_rst_done",    {31'd0, a_done},   32'd0);
        @(posedge clk); @(posedge clk); #1;
        n_rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (a_done || a_strobe) seen++;
        end
        check("mid_rst_quiet", seen, 0);

        // LSB-first instance with shift_en high every third cycle.
        b_valid = 1'b1; b_data = 8'h01; b_last = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        bits = 16'h0000; n = 0; done_at = -1; prev_at = -1; first_at = -1;
        gap_err = 0; hold_err = 0; held = 1'b1;
        for (int c = 0; c < 60; c++) begin
            b_shift = (c % 3 == 0);
            @(posedge clk); #1;
            if (b_done) begin done_at = c; break; end
            if (b_strobe) begin
                bits = {bits[14:0], b_bit}; n++;
                if (first_at < 0) first_at = c;
                if (prev_at >= 0 && c - prev_at != 3) gap_err++;
                prev_at = c; held = b_bit;
            end else if (n > 0 && b_bit !== held) begin
                hold_err++;
            end
        end
        b_shift = 1'b0;
        check("lsb_count",    n, 8);
        check("lsb_bits",     {16'h0000, bits}, 32'h0000_00AA);
        check("lsb_first_at", first_at, 0);
        check("lsb_spacing",  gap_err, 0);
        check("lsb_hold",     hold_err, 0);
        check("lsb_done",     done_at, prev_at + 1);
        check("lsb_stuff",    {31'd0, b_stuff}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
